// File: rtl/prbs_gen_chk_param.sv
// PRBS link-test block: preamble + PRBS7/15/23/31 word generator and a detector
// that finds n repeated preambles, then aligns its own LFSR and counts word errors.
module prbs_gen_chk_param #(
    parameter int WORD_W    = 8,
    parameter int NUM_WORDS = 4,
    parameter int CNT_W     = 4,
    parameter int LEN_W     = 16,
    parameter int ERR_W     = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [WORD_W*NUM_WORDS-1:0] data_in,
    input  logic [CNT_W-1:0]            n,
    input  logic [1:0]                  prbs_mode,
    input  logic [LEN_W-1:0]            prbs_len,
    input  logic                        loopback,
    input  logic [WORD_W-1:0]           rx_data,
    input  logic                        rx_valid,
    output logic [WORD_W-1:0]           data_out,
    output logic                        data_valid,
    output logic                        busy,
    output logic                        done,
    output logic                        data_flag,
    output logic [ERR_W-1:0]            err_cnt,
    output logic [1:0]                  dbg_gen_state,
    output logic                        dbg_det_state
);
    // Streams carry no backpressure: a word is transferred on every cycle its
    // valid is high (data_valid for data_out, rx_valid for rx_data).

    localparam int IDX_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

    typedef enum logic [1:0] {G_IDLE, G_PATTERN, G_PRBS, G_DONE} gen_state_t;
    typedef enum logic {D_SEARCH, D_CHECK} det_state_t;

    function automatic logic [30:0] lfsr_seed(input logic [1:0] mode);
        case (mode)
            2'b00:   lfsr_seed = 31'h0000_007F;
            2'b01:   lfsr_seed = 31'h0000_7FFF;
            2'b10:   lfsr_seed = 31'h007F_FFFF;
            default: lfsr_seed = 31'h7FFF_FFFF;
        endcase
    endfunction

    // Advances WORD_W bits; returns {next_state, word}, first bit in word bit 0.
    function automatic logic [31+WORD_W-1:0] lfsr_step(input logic [30:0] s_in, input logic [1:0] mode);
        logic [30:0]       s;
        logic [WORD_W-1:0] w;
        logic [4:0]        hi;
        logic [4:0]        tp;
        logic              b;
        case (mode)
            2'b00:   begin hi = 5'd6;  tp = 5'd5;  end
            2'b01:   begin hi = 5'd14; tp = 5'd13; end
            2'b10:   begin hi = 5'd22; tp = 5'd17; end
            default: begin hi = 5'd30; tp = 5'd27; end
        endcase
        s = s_in;
        w = '0;
        for (int i = 0; i < WORD_W; i++) begin
            b    = s[hi] ^ s[tp];
            s    = {s[29:0], b} & lfsr_seed(mode);
            w[i] = b;
        end
        return {s, w};
    endfunction

    gen_state_t        gen_state, gen_next;
    det_state_t        det_state, det_next;
    logic [WORD_W-1:0] pat_q [NUM_WORDS];
    logic [CNT_W-1:0]  n_q;
    logic [1:0]        mode_q;
    logic [LEN_W-1:0]  len_q;
    logic [IDX_W-1:0]  g_idx;
    logic [CNT_W-1:0]  g_rep;
    logic [LEN_W-1:0]  g_cnt;
    logic [30:0]       g_lfsr, g_lfsr_nxt;
    logic [WORD_W-1:0] g_word;
    logic [WORD_W-1:0] word_c;
    logic              valid_c;
    logic              launch;

    assign launch = start && (gen_state == G_IDLE);
    assign {g_lfsr_nxt, g_word} = lfsr_step(g_lfsr, mode_q);

    always_comb begin
        gen_next = gen_state;
        case (gen_state)
            G_IDLE: begin
                if (start) begin
                    if (n != '0)             gen_next = G_PATTERN;
                    else if (prbs_len != '0) gen_next = G_PRBS;
                    else                     gen_next = G_DONE;
                end
            end
            G_PATTERN: begin
                if (g_idx == LAST_IDX && g_rep == n_q - 1'b1)
                    gen_next = (len_q != '0) ? G_PRBS : G_DONE;
            end
            G_PRBS: begin
                if (g_cnt == len_q - 1'b1) gen_next = G_DONE;
            end
            default: gen_next = G_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) gen_state <= G_IDLE;
        else      gen_state <= gen_next;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_WORDS; i++) pat_q[i] <= '0;
            n_q    <= '0;
            mode_q <= '0;
            len_q  <= '0;
            g_idx  <= '0;
            g_rep  <= '0;
            g_cnt  <= '0;
            g_lfsr <= '1;
        end else if (launch) begin
            for (int i = 0; i < NUM_WORDS; i++) pat_q[i] <= data_in[i*WORD_W +: WORD_W];
            n_q    <= n;
            mode_q <= prbs_mode;
            len_q  <= prbs_len;
            g_idx  <= '0;
            g_rep  <= '0;
            g_cnt  <= '0;
            g_lfsr <= lfsr_seed(prbs_mode);
        end else if (gen_state == G_PATTERN) begin
            if (g_idx == LAST_IDX) begin
                g_idx <= '0;
                g_rep <= g_rep + 1'b1;
            end else begin
                g_idx <= g_idx + 1'b1;
            end
        end else if (gen_state == G_PRBS) begin
            g_cnt  <= g_cnt + 1'b1;
            g_lfsr <= g_lfsr_nxt;
        end
    end

    // Outputs are a registered copy of the state decode, one cycle behind the FSM.
    always_comb begin
        word_c  = '0;
        valid_c = 1'b0;
        if (gen_state == G_PATTERN) begin
            word_c  = pat_q[g_idx];
            valid_c = 1'b1;
        end else if (gen_state == G_PRBS) begin
            word_c  = g_word;
            valid_c = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_out   <= '0;
            data_valid <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            data_out   <= word_c;
            data_valid <= valid_c;
            busy       <= (gen_state != G_IDLE);
            done       <= (gen_state == G_DONE);
        end
    end

    logic [WORD_W-1:0] det_word;
    logic              det_vld;
    logic [IDX_W-1:0]  d_idx;
    logic [CNT_W-1:0]  d_rep, rep_inc;
    logic [30:0]       c_lfsr, c_lfsr_nxt;
    logic [WORD_W-1:0] c_word;
    logic              word_hit, first_hit, found;

    assign det_word  = loopback ? data_out : rx_data;
    assign det_vld   = loopback ? data_valid : rx_valid;
    assign {c_lfsr_nxt, c_word} = lfsr_step(c_lfsr, mode_q);
    assign word_hit  = (det_word == pat_q[d_idx]);
    assign first_hit = (NUM_WORDS > 1) && (det_word == pat_q[0]);
    assign rep_inc   = d_rep + 1'b1;
    assign found     = (det_state == D_SEARCH) && det_vld && word_hit &&
                       (d_idx == LAST_IDX) && (rep_inc == n_q) && (n_q != '0);

    always_comb begin
        det_next = det_state;
        if (launch)     det_next = D_SEARCH;
        else if (found) det_next = D_CHECK;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) det_state <= D_SEARCH;
        else      det_state <= det_next;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            d_idx     <= '0;
            d_rep     <= '0;
            data_flag <= 1'b0;
            err_cnt   <= '0;
            c_lfsr    <= '1;
        end else if (launch) begin
            d_idx     <= '0;
            d_rep     <= '0;
            data_flag <= 1'b0;
            err_cnt   <= '0;
        end else if (det_vld) begin
            if (det_state == D_SEARCH) begin
                if (word_hit) begin
                    if (d_idx == LAST_IDX) begin
                        d_idx <= '0;
                        d_rep <= rep_inc;
                    end else begin
                        d_idx <= d_idx + 1'b1;
                    end
                    if (found) begin
                        data_flag <= 1'b1;
                        c_lfsr    <= lfsr_seed(mode_q);
                    end
                end else begin
                    // A broken run may itself begin a new preamble.
                    d_rep <= '0;
                    d_idx <= first_hit ? IDX_W'(1) : '0;
                end
            end else begin
                c_lfsr <= c_lfsr_nxt;
                if (det_word != c_word && err_cnt != '1) err_cnt <= err_cnt + 1'b1;
            end
        end
    end

    assign dbg_gen_state = gen_state;
    assign dbg_det_state = det_state;

endmodule
